rs232_avalon_poll_master: RTL and testbench

//  Avalon-MM master that drives the RS232 UART slave's two-word register map, so hardware logic can use the UART without a CPU.

---
 rtl/rs232_avalon_poll_master.sv | 188 ++++++++++++++++++
 tb/tb_rs232_avalon_poll_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_avalon_poll_master.sv
// Avalon-MM polling master for the RS232 UART slave: RX bytes out on a valid/ready stream, TX bytes in.
// Optional macro RS232_POLL_MASTER_IRQ_EN adds an irq input that enables the read interrupt and forces an RX poll.
module rs232_avalon_poll_master #(
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  m_address,
  output logic                  m_chipselect,
  output logic [3:0]            m_byteenable,
  output logic                  m_read,
  output logic                  m_write,
  output logic [31:0]           m_writedata,
  input  logic [31:0]           m_readdata,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy
`ifdef RS232_POLL_MASTER_IRQ_EN
  ,
  input  logic                  irq
`endif
);

  localparam int unsigned CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL + 1) : 1;
  localparam int unsigned LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
`ifdef RS232_POLL_MASTER_IRQ_EN
  localparam logic [31:0] INIT_WORD = 32'h1;
`else
  localparam logic [31:0] INIT_WORD = 32'h0;
`endif

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_DATA, S_WAIT_DATA, S_RD_CTRL, S_WAIT_CTRL, S_WR_DATA
  } state_t;

  state_t                state_q;
  logic                  m_address_q, m_chipselect_q, m_read_q, m_write_q;
  logic [3:0]            m_byteenable_q;
  logic [31:0]           m_writedata_q;
  logic                  tx_ready_q, rx_valid_q, busy_q, prio_tx_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic [CW-1:0]         rx_cnt_q, tx_cnt_q;
  logic [LW-1:0]         lat_q;

  logic                  irq_w;
  logic [CW-1:0]         rx_cnt_eff;
  logic                  rx_elig, tx_elig, pick_rx;
  logic                  unused_rdata;

`ifdef RS232_POLL_MASTER_IRQ_EN
  assign irq_w = irq;
`else
  assign irq_w = 1'b0;
`endif

  assign unused_rdata = &{1'b0, m_readdata};

  always_comb begin
    rx_cnt_eff = irq_w ? '0 : rx_cnt_q;
    rx_elig    = !rx_valid_q && (rx_cnt_eff == '0);
    tx_elig    = tx_valid && (tx_cnt_q == '0);
    pick_rx    = rx_elig && (!tx_elig || !prio_tx_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_INIT;
      m_address_q    <= 1'b0;
      m_chipselect_q <= 1'b0;
      m_byteenable_q <= '0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      tx_ready_q     <= 1'b0;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      busy_q         <= 1'b0;
      prio_tx_q      <= 1'b0;
      rx_cnt_q       <= '0;
      tx_cnt_q       <= '0;
      lat_q          <= '0;
    end else begin
      // Strobes default low so every access is a single-cycle pulse.
      m_address_q    <= 1'b0;
      m_chipselect_q <= 1'b0;
      m_byteenable_q <= '0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      tx_ready_q     <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        S_INIT: begin
          if (!m_write_q) begin
            m_chipselect_q <= 1'b1;
            m_write_q      <= 1'b1;
            m_address_q    <= 1'b1;
            m_byteenable_q <= 4'b0001;
            m_writedata_q  <= INIT_WORD;
            busy_q         <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          rx_cnt_q <= (rx_cnt_eff != '0) ? rx_cnt_eff - 1'b1 : '0;
          if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - 1'b1;
          if (pick_rx || tx_elig) begin
            m_chipselect_q <= 1'b1;
            m_read_q       <= 1'b1;
            m_byteenable_q <= 4'b0001;
            m_address_q    <= !pick_rx;
            prio_tx_q      <= pick_rx;
            busy_q         <= 1'b1;
            state_q        <= pick_rx ? S_RD_DATA : S_RD_CTRL;
          end
        end
        S_RD_DATA: begin
          lat_q   <= LW'(READ_LATENCY - 1);
          state_q <= S_WAIT_DATA;
        end
        S_WAIT_DATA: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else begin
            if (m_readdata[23:16] != 8'h0) begin
              rx_data_q  <= m_readdata[DATA_WIDTH-1:0];
              rx_valid_q <= 1'b1;
              rx_cnt_q   <= '0;
            end else begin
              rx_cnt_q <= CW'(POLL_INTERVAL - 1);
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RD_CTRL: begin
          lat_q   <= LW'(READ_LATENCY - 1);
          state_q <= S_WAIT_CTRL;
        end
        S_WAIT_CTRL: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else if (m_readdata[23:16] == 8'h0) begin
            tx_cnt_q <= CW'(POLL_INTERVAL - 1);
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (tx_valid) begin
            m_chipselect_q <= 1'b1;
            m_write_q      <= 1'b1;
            m_byteenable_q <= 4'b0001;
            m_writedata_q  <= 32'(tx_data);
            tx_ready_q     <= 1'b1;
            state_q        <= S_WR_DATA;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WR_DATA: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign m_address    = m_address_q;
  assign m_chipselect = m_chipselect_q;
  assign m_byteenable = m_byteenable_q;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_writedata_q;
  assign tx_ready     = tx_ready_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rs232_avalon_poll_master.sv
// Directed bench for rs232_avalon_poll_master with a behavioural UART slave (latency-1 readdata).
module tb_rs232_avalon_poll_master;
  localparam int PI = 16;
`ifdef RS232_POLL_MASTER_IRQ_EN
  localparam logic [31:0] INIT_EXP = 32'h1;
`else
  localparam logic [31:0] INIT_EXP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m_address, m_chipselect, m_read, m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] s_rdata = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        busy;
`ifdef RS232_POLL_MASTER_IRQ_EN
  logic        irq = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          wr;
    bit          adr;
    logic [31:0] d;
  } acc_t;

  acc_t        acc_log[$];
  logic [7:0]  rxq[$];
  logic [7:0]  rx_log[$];
  logic [7:0]  space = '0;
  int          cyc = 0;
  int          last_rd = -10;
  int          txr_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  rs232_avalon_poll_master #(
    .READ_LATENCY (1),
    .POLL_INTERVAL(PI),
    .DATA_WIDTH   (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_address   (m_address),
    .m_chipselect(m_chipselect),
    .m_byteenable(m_byteenable),
    .m_read      (m_read),
    .m_write     (m_write),
    .m_writedata (m_writedata),
    .m_readdata  (s_rdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy)
`ifdef RS232_POLL_MASTER_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  // UART slave model plus bus-rule monitor
  always @(posedge clk) begin
    acc_t       a;
    logic [7:0] b;
    cyc = cyc + 1;
    if (m_chipselect) begin
      tests++;
      if (!(m_read ^ m_write) || m_byteenable !== 4'b0001 || cyc == last_rd + 1) begin
        fails++;
        $display("FAIL bus_rule: cyc %0d rd=%b wr=%b be=%b last_rd=%0d, want one strobe, be 0001, no access during read",
                 cyc, m_read, m_write, m_byteenable, last_rd);
      end
      a.cyc = cyc; a.wr = m_write; a.adr = m_address; a.d = m_writedata;
      if (m_read) begin
        last_rd = cyc;
        if (m_address) begin
          a.d = {8'h0, space, 16'h0};
        end else if (rxq.size() > 0) begin
          a.d = {8'h0, 8'(rxq.size()), 8'h0, 8'h0};
          b = rxq.pop_front();
          a.d[7:0] = b;
        end else begin
          a.d = 32'h0;
        end
        s_rdata <= a.d;
      end
      acc_log.push_back(a);
    end
    if (tx_ready) txr_cnt++;
    if (rx_valid && rx_ready) rx_log.push_back(rx_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit found = 0;
    reset_n = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; space = 8'd0;
    repeat (3) tick();
    tests++;
    if ({m_chipselect, m_read, m_write, m_address, tx_ready, rx_valid, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, want 0000000", {m_chipselect, m_read, m_write, m_address, tx_ready, rx_valid, busy});
    end
    tests++;
    if (m_byteenable !== 4'b0 || m_writedata !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: be=%b wd=%h, want 0/0", m_byteenable, m_writedata);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_chipselect) begin found = 1; break; end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL init_timeout: got no access, want INIT write");
    end else begin
      tests++;
      if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 1'b1) begin
        fails++;
        $display("FAIL init_kind: wr=%b rd=%b adr=%b, want 1/0/1", m_write, m_read, m_address);
      end
      tests++;
      if (m_writedata !== INIT_EXP || m_byteenable !== 4'b0001) begin
        fails++;
        $display("FAIL init_data: wd=%h be=%b, want %h/0001", m_writedata, m_byteenable, INIT_EXP);
      end
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL init_busy: got %b, want 1", busy);
      end
      tick();
      tests++;
      if (m_chipselect !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL init_end: cs=%b busy=%b, want 0/0", m_chipselect, busy);
      end
    end
  endtask

  task automatic test_rx_fifo();
    int   start, rxs;
    acc_t rd[$];
    rx_ready = 1'b1;
    rxs = rx_log.size();
    rxq.push_back(8'h41); rxq.push_back(8'h42); rxq.push_back(8'h43);
    start = acc_log.size();
    for (int i = 0; i < 300; i++) begin
      tick();
      rd.delete();
      for (int j = start; j < acc_log.size(); j++)
        if (!acc_log[j].wr && !acc_log[j].adr) rd.push_back(acc_log[j]);
      if (rd.size() >= 5) break;
    end
    tests++;
    if (rd.size() < 5 || rx_log.size() < rxs + 3) begin
      fails++;
      $display("FAIL rx_timeout: reads=%0d bytes=%0d, want 5/3", rd.size(), rx_log.size() - rxs);
    end else begin
      tests++;
      if (rx_log[rxs] !== 8'h41 || rx_log[rxs+1] !== 8'h42 || rx_log[rxs+2] !== 8'h43) begin
        fails++;
        $display("FAIL rx_order: got %h %h %h, want 41 42 43", rx_log[rxs], rx_log[rxs+1], rx_log[rxs+2]);
      end
      tests++;
      if (rd[0].d[23:16] !== 8'd3 || rd[1].d[23:16] !== 8'd2 || rd[2].d[23:16] !== 8'd1) begin
        fails++;
        $display("FAIL rx_counts: got %0d %0d %0d, want 3 2 1", rd[0].d[23:16], rd[1].d[23:16], rd[2].d[23:16]);
      end
      tests++;
      if (rd[3].d[23:16] !== 8'd0 || rd[4].cyc - rd[3].cyc < PI) begin
        fails++;
        $display("FAIL rx_backoff: empty_cnt=%0d gap=%0d, want 0 and gap >= %0d", rd[3].d[23:16], rd[4].cyc - rd[3].cyc, PI);
      end
    end
  endtask

  task automatic test_tx_write();
    int  start, t0, widx = -1, nwr = 0;
    bit  got = 0;
    space = 8'd64; tx_data = 8'h55; tx_valid = 1'b1;
    start = acc_log.size(); t0 = txr_cnt;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (tx_ready) got = 1;
    end
    tick();
    tx_valid = 1'b0;
    repeat (30) tick();
    for (int j = start; j < acc_log.size(); j++)
      if (acc_log[j].wr) begin nwr++; if (widx < 0) widx = j; end
    tests++;
    if (!got || widx < 1) begin
      fails++;
      $display("FAIL tx_timeout: got no write, want one write of 55");
    end else begin
      tests++;
      if (acc_log[widx].adr !== 1'b0 || acc_log[widx].d !== 32'h55) begin
        fails++;
        $display("FAIL tx_write: adr=%b data=%h, want 0/00000055", acc_log[widx].adr, acc_log[widx].d);
      end
      tests++;
      if (acc_log[widx-1].wr || acc_log[widx-1].adr !== 1'b1 || acc_log[widx].cyc - acc_log[widx-1].cyc != 2) begin
        fails++;
        $display("FAIL tx_ctrl_first: prev wr=%b adr=%b gap=%0d, want ctrl read 2 cycles before",
                 acc_log[widx-1].wr, acc_log[widx-1].adr, acc_log[widx].cyc - acc_log[widx-1].cyc);
      end
      tests++;
      if (nwr != 1 || txr_cnt - t0 != 1) begin
        fails++;
        $display("FAIL tx_once: writes=%0d pulses=%0d, want 1/1", nwr, txr_cnt - t0);
      end
    end
  endtask

  task automatic test_tx_nospace();
    int   start, t0, nwr = 0, widx = -1;
    bit   got = 0;
    acc_t cr[$];
    space = 8'd0; tx_data = 8'hA7; tx_valid = 1'b1;
    start = acc_log.size();
    for (int i = 0; i < 300; i++) begin
      tick();
      cr.delete();
      for (int j = start; j < acc_log.size(); j++)
        if (!acc_log[j].wr && acc_log[j].adr) cr.push_back(acc_log[j]);
      if (cr.size() >= 2) break;
    end
    for (int j = start; j < acc_log.size(); j++) if (acc_log[j].wr) nwr++;
    tests++;
    if (cr.size() < 2 || nwr != 0 || cr[1].cyc - cr[0].cyc < PI) begin
      fails++;
      $display("FAIL tx_full: ctrl_reads=%0d writes=%0d, want 2 reads >= %0d apart and 0 writes", cr.size(), nwr, PI);
    end
    space = 8'd1;
    start = acc_log.size(); t0 = txr_cnt; nwr = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (tx_ready) got = 1;
    end
    tick();
    tx_valid = 1'b0;
    repeat (30) tick();
    for (int j = start; j < acc_log.size(); j++)
      if (acc_log[j].wr) begin nwr++; if (widx < 0) widx = j; end
    tests++;
    if (!got || nwr != 1 || txr_cnt - t0 != 1) begin
      fails++;
      $display("FAIL tx_space1: writes=%0d pulses=%0d, want 1/1", nwr, txr_cnt - t0);
    end else begin
      tests++;
      if (acc_log[widx].d !== 32'hA7 || acc_log[widx].adr !== 1'b0) begin
        fails++;
        $display("FAIL tx_space1_data: got %h, want 000000a7", acc_log[widx].d);
      end
    end
  endtask

  task automatic test_rx_hold();
    int  idx, rxs, nrd = 0;
    bit  got = 0, bad = 0;
    rx_ready = 1'b0;
    rxs = rx_log.size();
    rxq.push_back(8'h61); rxq.push_back(8'h62);
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (rx_valid) got = 1;
    end
    tests++;
    if (!got || rx_data !== 8'h61) begin
      fails++;
      $display("FAIL hold_capture: valid=%b data=%h, want 1/61", rx_valid, rx_data);
    end
    idx = acc_log.size();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rx_valid !== 1'b1 || rx_data !== 8'h61) bad = 1;
    end
    for (int j = idx; j < acc_log.size(); j++) if (!acc_log[j].wr && !acc_log[j].adr) nrd++;
    tests++;
    if (bad || nrd != 0) begin
      fails++;
      $display("FAIL hold_stall: unstable=%b data_reads=%0d, want 0/0", bad, nrd);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < 100 && rx_log.size() < rxs + 2; i++) tick();
    tests++;
    if (rx_log.size() < rxs + 2) begin
      fails++;
      $display("FAIL hold_release: got %0d bytes, want 2", rx_log.size() - rxs);
    end else if (rx_log[rxs] !== 8'h61 || rx_log[rxs+1] !== 8'h62) begin
      fails++;
      $display("FAIL hold_release: got %h %h, want 61 62", rx_log[rxs], rx_log[rxs+1]);
    end
  endtask

  task automatic test_reset_mid();
    int rxs;
    bit got = 0, found = 0;
    rx_ready = 1'b1;
    rxq.push_back(8'h77);
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (m_read && !m_address) got = 1;
    end
    rxs = rx_log.size();
    tick();
    reset_n = 1'b0;
    #1;
    tests++;
    if (!got || {m_chipselect, m_read, m_write, tx_ready, rx_valid, busy} !== 6'b0 || m_byteenable !== 4'b0) begin
      fails++;
      $display("FAIL mid_reset: saw_read=%b outs=%b be=%b, want 1/000000/0000", got,
               {m_chipselect, m_read, m_write, tx_ready, rx_valid, busy}, m_byteenable);
    end
    repeat (2) tick();
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (m_chipselect) found = 1;
    end
    tests++;
    if (!found || m_write !== 1'b1 || m_address !== 1'b1 || m_writedata !== INIT_EXP) begin
      fails++;
      $display("FAIL mid_reinit: found=%b wr=%b adr=%b wd=%h, want 1/1/1/%h", found, m_write, m_address, m_writedata, INIT_EXP);
    end
    repeat (40) tick();
    tests++;
    if (rx_log.size() != rxs) begin
      fails++;
      $display("FAIL mid_discard: got %0d bytes delivered, want 0", rx_log.size() - rxs);
    end
  endtask

`ifdef RS232_POLL_MASTER_IRQ_EN
  task automatic test_irq();
    int start;
    bit got = 0, found = 0;
    rx_ready = 1'b1;
    start = acc_log.size();
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      for (int j = start; j < acc_log.size(); j++) if (!acc_log[j].wr && !acc_log[j].adr) got = 1;
    end
    repeat (3) tick();
    irq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) irq = 1'b0;
      if (m_read && !m_address) found = 1;
    end
    tests++;
    if (!got || !found) begin
      fails++;
      $display("FAIL irq_poll: empty_read=%b irq_read=%b, want 1/1", got, found);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_fifo();
    test_tx_write();
    test_tx_nospace();
    test_rx_hold();
    test_reset_mid();
`ifdef RS232_POLL_MASTER_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
